// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder feeding a small output FIFO with valid/ready on both sides.
// Optional macro IMM_CHECK_EN adds per-format immediate range/alignment checking.
module instr_encoder #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CW    = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [6:0]                 opcode_in,
   input  logic [2:0]                 funct3_in,
   input  logic [6:0]                 funct7_in,
   input  logic [4:0]                 rs1_addr_in,
   input  logic [4:0]                 rs2_addr_in,
   input  logic [4:0]                 rd_addr_in,
   input  logic [31:0]                imm_in,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                instr_out,
   output logic                       err_out,
   output logic [$clog2(DEPTH):0]     level_out,
   output logic [CW-1:0]              enc_cnt_out
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_ALI    = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_ALU    = 7'b0110011;
   localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

   typedef struct packed {
      logic        err;
      logic [31:0] instr;
   } entry_t;

   entry_t          mem_q [DEPTH];
   entry_t          new_entry_c;
   entry_t          head_q, head_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            out_valid_q, out_valid_d;
   logic            in_ready_q, in_ready_d;
   logic            push_c, pop_c;
   logic [31:0]     word_c;
   logic            bad_c;

   // Field packing per format; unknown opcodes become a flagged NOP
   always_comb begin
      word_c = NOP_WORD;
      bad_c  = 1'b0;
      unique case (opcode_in)
         OPC_LOAD, OPC_ALI, OPC_JALR: begin
            word_c = {imm_in[11:0], rs1_addr_in, funct3_in, rd_addr_in, opcode_in};
`ifdef IMM_CHECK_EN
            bad_c  = (imm_in != {{20{imm_in[11]}}, imm_in[11:0]});
`endif
         end
         OPC_STORE: begin
            word_c = {imm_in[11:5], rs2_addr_in, rs1_addr_in, funct3_in, imm_in[4:0], opcode_in};
`ifdef IMM_CHECK_EN
            bad_c  = (imm_in != {{20{imm_in[11]}}, imm_in[11:0]});
`endif
         end
         OPC_BRANCH: begin
            word_c = {imm_in[12], imm_in[10:5], rs2_addr_in, rs1_addr_in, funct3_in,
                      imm_in[4:1], imm_in[11], opcode_in};
`ifdef IMM_CHECK_EN
            bad_c  = imm_in[0] || (imm_in != {{19{imm_in[12]}}, imm_in[12:0]});
`endif
         end
         OPC_JAL: begin
            word_c = {imm_in[20], imm_in[10:1], imm_in[11], imm_in[19:12], rd_addr_in, opcode_in};
`ifdef IMM_CHECK_EN
            bad_c  = imm_in[0] || (imm_in != {{11{imm_in[20]}}, imm_in[20:0]});
`endif
         end
         OPC_LUI, OPC_AUIPC: begin
            word_c = {imm_in[31:12], rd_addr_in, opcode_in};
`ifdef IMM_CHECK_EN
            bad_c  = (imm_in[11:0] != 12'h000);
`endif
         end
         OPC_ALU: begin
            word_c = {funct7_in, rs2_addr_in, rs1_addr_in, funct3_in, rd_addr_in, opcode_in};
         end
         default: begin
            word_c = NOP_WORD;
            bad_c  = 1'b1;
         end
      endcase
      new_entry_c.err   = bad_c;
      new_entry_c.instr = word_c;
   end

   // FIFO bookkeeping; flush overrides both push and pop
   always_comb begin
      push_c      = in_valid && in_ready_q && !flush;
      pop_c       = out_valid_q && out_ready && !flush;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      cnt_d       = cnt_q;
      head_d      = '0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (push_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            cnt_d    = cnt_q + CW'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         case ({push_c, pop_c})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
         endcase
      end
      out_valid_d = (level_d != '0);
      in_ready_d  = (level_d < LW'(DEPTH));
      // Head is the incoming bundle when it lands in the slot about to be presented
      if (level_d != '0) begin
         if (push_c && (wr_ptr_q == rd_ptr_d)) begin
            head_d = new_entry_c;
         end else begin
            head_d = mem_q[rd_ptr_d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_c) begin
         mem_q[wr_ptr_q] <= new_entry_c;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         cnt_q       <= '0;
         head_q      <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         cnt_q       <= cnt_d;
         head_q      <= head_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign instr_out   = head_q.instr;
   assign err_out     = head_q.err;
   assign level_out   = level_q;
   assign enc_cnt_out = cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder (DEPTH=4, CW=16).
module tb_instr_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [6:0]  opcode_in;
   logic [2:0]  funct3_in;
   logic [6:0]  funct7_in;
   logic [4:0]  rs1_addr_in;
   logic [4:0]  rs2_addr_in;
   logic [4:0]  rd_addr_in;
   logic [31:0] imm_in;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] instr_out;
   logic        err_out;
   logic [2:0]  level_out;
   logic [15:0] enc_cnt_out;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef IMM_CHECK_EN
   localparam logic IMM_ERR = 1'b1;
`else
   localparam logic IMM_ERR = 1'b0;
`endif

   instr_encoder #(.DEPTH(4), .CW(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .opcode_in   (opcode_in),
      .funct3_in   (funct3_in),
      .funct7_in   (funct7_in),
      .rs1_addr_in (rs1_addr_in),
      .rs2_addr_in (rs2_addr_in),
      .rd_addr_in  (rd_addr_in),
      .imm_in      (imm_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .instr_out   (instr_out),
      .err_out     (err_out),
      .level_out   (level_out),
      .enc_cnt_out (enc_cnt_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] imm);
      opcode_in   = op;
      funct3_in   = f3;
      funct7_in   = f7;
      rs1_addr_in = rs1;
      rs2_addr_in = rs2;
      rd_addr_in  = rd;
      imm_in      = imm;
   endtask

   task automatic push_one(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] imm);
      set_fields(op, f3, f7, rs1, rs2, rd, imm);
      in_valid = 1'b1;
      cycle();
      in_valid = 1'b0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
   endtask

   // Push one bundle into an empty FIFO, check the head, then drain it
   task automatic enc_check(input string tag, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic [31:0] imm,
                            input logic [31:0] exp_word, input logic exp_err);
      push_one(op, f3, f7, rs1, rs2, rd, imm);
      chk({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
      chk({tag, "_word"},  64'(instr_out), 64'(exp_word));
      chk({tag, "_err"},   64'(err_out),   64'(exp_err));
      pop_one();
      chk({tag, "_drained"}, 64'(out_valid), 64'(1'b0));
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      set_fields(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      #12;
      chk("rst_level", 64'(level_out),   64'd0);
      chk("rst_valid", 64'(out_valid),   64'd0);
      chk("rst_instr", 64'(instr_out),   64'd0);
      chk("rst_err",   64'(err_out),     64'd0);
      chk("rst_cnt",   64'(enc_cnt_out), 64'd0);
      rst_n = 1'b1;
      cycle();
      chk("rst_ready", 64'(in_ready), 64'd1);

      enc_check("addi",  7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5,          32'h0050_0093, 1'b0);
      chk("cnt_after_addi", 64'(enc_cnt_out), 64'd1);
      enc_check("sw",    7'b0100011, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8,          32'h0020_A423, 1'b0);
      enc_check("beq",   7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC,  32'hFE00_0EE3, 1'b0);
      enc_check("jal",   7'b1101111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0800,  32'h0010_00EF, 1'b0);
      enc_check("lui",   7'b0110111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000,  32'h1234_52B7, 1'b0);
      enc_check("sub",   7'b0110011, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'd0,         32'h4020_81B3, 1'b0);
      enc_check("illeg", 7'h7F,      3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0,          32'h0000_0013, 1'b1);
      chk("cnt_after_illeg", 64'(enc_cnt_out), 64'd7);
      enc_check("beq3",  7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3,          32'h0000_0163, IMM_ERR);
      enc_check("addi800", 7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h800,      32'h8000_0013, IMM_ERR);
      chk("cnt_after_imm", 64'(enc_cnt_out), 64'd9);

      // Backpressure: fill to DEPTH, fifth bundle must wait
      for (int i = 1; i <= 4; i++) begin
         push_one(7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'(i));
      end
      chk("full_level", 64'(level_out), 64'd4);
      chk("full_ready", 64'(in_ready),  64'd0);
      chk("full_head",  64'(instr_out), 64'h0010_0013);
      set_fields(7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd5);
      in_valid = 1'b1;
      cycle();
      chk("held_level", 64'(level_out),   64'd4);
      chk("held_cnt",   64'(enc_cnt_out), 64'd13);
      chk("held_head",  64'(instr_out),   64'h0010_0013);
      out_ready = 1'b1;
      cycle();
      chk("pop1_level", 64'(level_out), 64'd3);
      chk("pop1_head",  64'(instr_out), 64'h0020_0013);
      chk("pop1_ready", 64'(in_ready),  64'd1);
      cycle();
      in_valid = 1'b0;
      chk("pp_level", 64'(level_out),   64'd3);
      chk("pp_head",  64'(instr_out),   64'h0030_0013);
      chk("pp_cnt",   64'(enc_cnt_out), 64'd14);
      cycle();
      chk("drain_d", 64'(instr_out), 64'h0040_0013);
      cycle();
      chk("drain_e", 64'(instr_out), 64'h0050_0013);
      chk("drain_e_level", 64'(level_out), 64'd1);
      cycle();
      out_ready = 1'b0;
      chk("drain_empty", 64'(out_valid), 64'd0);
      chk("drain_instr", 64'(instr_out), 64'd0);

      // Flush with three entries; same-cycle push is dropped
      for (int i = 0; i < 3; i++) begin
         push_one(7'b0110111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd2, 32'h0000_1000);
      end
      chk("preflush_level", 64'(level_out), 64'd3);
      flush    = 1'b1;
      in_valid = 1'b1;
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("flush_level", 64'(level_out),   64'd0);
      chk("flush_valid", 64'(out_valid),   64'd0);
      chk("flush_cnt",   64'(enc_cnt_out), 64'd17);

      // Asynchronous reset mid-stream
      push_one(7'b0010011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd7);
      push_one(7'h00,      3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      chk("prerst_cnt", 64'(enc_cnt_out), 64'd19);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_level", 64'(level_out),   64'd0);
      chk("arst_valid", 64'(out_valid),   64'd0);
      chk("arst_instr", 64'(instr_out),   64'd0);
      chk("arst_cnt",   64'(enc_cnt_out), 64'd0);
      #3;
      rst_n = 1'b1;
      cycle();
      enc_check("post_rst", 7'b0010111, 3'd0, 7'd0, 5'd0, 5'd0, 5'd4, 32'h0000_2000, 32'h0000_2217, 1'b0);
      chk("post_rst_cnt", 64'(enc_cnt_out), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Turns RV32I instruction fields (opcode, funct3, funct7, register addresses, 32-bit immediate) back into a 32-bit instruction word. It is the inverse of the core's field/immediate decoder.
- Fields enter on a valid/ready port and are encoded combinationally. The word is then buffered in a small FIFO and drained on a second valid/ready port.
- Used by the debug instruction injector and the boot-sequence generator to feed the fetch stage.

Parameters:
- DEPTH, 4, output FIFO entries; power of two, minimum 2.
- CW, 16, width of the encoded-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous FIFO clear.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- opcode_in  in  7  instruction opcode.
- funct3_in  in  3  funct3.
- funct7_in  in  7  funct7; used only for R-format.
- rs1_addr_in  in  5  rs1 address.
- rs2_addr_in  in  5  rs2 address.
- rd_addr_in  in  5  rd address.
- imm_in  in  32  immediate, in decoder convention (sign-extended; B/J byte offsets; U already shifted left by 12).
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- instr_out  out  32  encoded word at FIFO head.
- err_out  out  1  error flag stored with the head entry.
- level_out  out  $clog2(DEPTH)+1  FIFO occupancy.
- enc_cnt_out  out  CW  count of accepted bundles.

Behaviour:
- Reset (async, rst_n=0): FIFO empty, level_out=0, out_valid=0, instr_out=0, err_out=0, enc_cnt_out=0. in_ready=1 after reset release.
- Format selection by opcode (OPC_* values from DEFINE.vh):
  - I-format: LOAD 0000011, ALI 0010011, JALR 1100111. Layout {imm[11:0],rs1,f3,rd,op}.
  - S-format: STORE 0100011. Layout {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - B-format: BRANCH 1100011. Layout {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - J-format: JAL 1101111. Layout {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
  - U-format: LUI 0110111, AUIPC 0010111. Layout {imm[31:12],rd,op}.
  - R-format: ALU 0110011. Layout {f7,rs2,rs1,f3,rd,op}.
  - Any other opcode: word=32'h00000013 (NOP), err=1.
- Accept: push occurs when in_valid && in_ready. in_ready = (level_out < DEPTH). There is no combinational path from out_ready to in_ready, so a full FIFO never accepts, even while popping.
- Latency: a bundle accepted at edge N appears at the head with out_valid=1 after edge N (1 cycle) when the FIFO was empty.
- Pop: pop occurs when out_valid && out_ready. The next entry is presented after that edge.
- Simultaneous push and pop with a non-empty FIFO: level is unchanged and order is preserved.
- instr_out and err_out hold their value while out_valid && !out_ready. When the FIFO is empty, instr_out=0 and err_out=0.
- Pointers wrap modulo DEPTH.
- enc_cnt_out increments once per push, including error pushes, and wraps from 2^CW-1 to 0.
- flush=1: FIFO is emptied at the next edge and any same-cycle push is dropped; enc_cnt_out is not cleared. flush dominates push and pop.
- An rst_n assertion mid-stream discards all entries immediately.

Optional Feature:
- Macro: IMM_CHECK_EN.
- Defined: imm_in is range- and alignment-checked per format. A failing bundle is still pushed with its truncated encoding and err=1.
  - I/S: imm_in must equal the sign-extension of imm_in[11:0].
  - B: imm_in[0]=0 and it fits a 13-bit signed range.
  - J: imm_in[0]=0 and it fits a 21-bit signed range.
  - U: imm_in[11:0]=0.
- Undefined: no checks. Upper bits are silently truncated, and err flags only illegal opcodes.

Test Plan:
- ADDI: op=0010011, f3=0, rd=1, rs1=0, imm=5 -> instr_out=0x00500093, err=0, out_valid one cycle after accept.
- Stores and branches: SW rs1=1, rs2=2, imm=8 -> 0x0020A423; BEQ rs1=rs2=0, imm=-4 -> 0xFE000EE3.
- Jumps and upper immediates: JAL rd=1, imm=0x800 -> 0x001000EF; LUI rd=5, imm=0x12345000 -> 0x123452B7.
- Illegal opcode: opcode=0x7F -> instr_out=0x00000013, err=1, enc_cnt_out increments.
- Backpressure: DEPTH=4, out_ready=0, five pushes attempted -> in_ready=0 after the 4th, level_out=4, 5th held. Then out_ready=1 -> FIFO order preserved; a simultaneous push/pop keeps level constant.
- Imm checks (IMM_CHECK_EN defined): BEQ imm=3 -> err=1; ADDI imm=0x800 -> err=1. Without the macro both give err=0.
- Flush and reset: flush with 3 entries -> level_out=0 next cycle, enc_cnt unchanged. rst_n low mid-stream -> all outputs at reset values immediately.
